// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in
//   over a valid/ready handshake. It then drives one external 1-bit full adder
//   LSB-first, one bit per clock. When all bits are done it returns the sum and
//   the final carry over a second valid/ready handshake.
//
//   Optional feature: define SERIAL_ADD_OVF_EN to register the two's-complement
//   overflow flag. When the macro is not defined, ovf is tied to 0.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   op_a, op_b, op_cin  operands, sampled only on the accept edge
//   fa_a, fa_b, fa_c_in to the external full adder (all 0 outside RUN)
//   fa_sum, fa_c_out    from the external full adder (combinational)
//   out_valid/out_ready result handshake (valid only in DONE)
//   res_sum, res_cout   low WIDTH bits of A+B+cin, and the carry out of the MSB
//   ovf                 signed overflow (only with SERIAL_ADD_OVF_EN)
//   busy                high in RUN or DONE
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c_in,
  input  logic             fa_sum,
  input  logic             fa_c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Each new sum bit enters at the MSB. After WIDTH shifts, bit 0 holds
        // the LSB. This form also stays legal when WIDTH is 1.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = fa_c_out;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final edge.
          ovf_d   = carry_q ^ fa_c_out;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign fa_a      = (state_q == S_RUN) & a_q[0];
  assign fa_b      = (state_q == S_RUN) & b_q[0];
  assign fa_c_in   = (state_q == S_RUN) & carry_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule
